// File: rtl/mod_u_cnt_ctrl_pkg.sv
// Shared op codes, state encodings and helpers for the mod-U BCD counter command sequencer.
package mod_u_cnt_ctrl_pkg;

   localparam int OP_W = 3;
   localparam int ST_W = 3;

   localparam logic [OP_W-1:0] OP_NOP    = 3'd0;
   localparam logic [OP_W-1:0] OP_CLEAR  = 3'd1;
   localparam logic [OP_W-1:0] OP_LOAD   = 3'd2;
   localparam logic [OP_W-1:0] OP_RUN_UP = 3'd3;
   localparam logic [OP_W-1:0] OP_RUN_DN = 3'd4;
   localparam logic [OP_W-1:0] OP_STOP   = 3'd5;
   localparam logic [OP_W-1:0] OP_RUN_TO = 3'd6;
   localparam logic [OP_W-1:0] OP_STEP   = 3'd7;

   localparam logic [ST_W-1:0] ST_IDLE  = 3'd0;
   localparam logic [ST_W-1:0] ST_CLR   = 3'd1;
   localparam logic [ST_W-1:0] ST_LD    = 3'd2;
   localparam logic [ST_W-1:0] ST_RUN   = 3'd3;
   localparam logic [ST_W-1:0] ST_RUNTO = 3'd4;
   localparam logic [ST_W-1:0] ST_STEP  = 3'd5;

   // New ops are only taken while idle or while a run can be preempted.
   function automatic logic ready_in_state(input logic [ST_W-1:0] st);
      return (st == ST_IDLE) || (st == ST_RUN) || (st == ST_RUNTO);
   endfunction

endpackage

// File: rtl/mod_u_cnt_ctrl.sv
// Command sequencer for the mod-U BCD counter: turns valid/ready ops into
// registered counter strobes, gated by the freq_div tick.
module mod_u_cnt_ctrl
   import mod_u_cnt_ctrl_pkg::*;
#(
   parameter int DW    = 4,
   parameter int MOD_U = 10
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            tick_in,
   input  logic            cmd_valid,
   output logic            cmd_ready,
   input  logic [OP_W-1:0] cmd_op,
   input  logic [DW-1:0]   cmd_data,
   input  logic [DW-1:0]   cnt_q,
   output logic            cnt_en,
   output logic            cnt_clr,
   output logic            cnt_up,
   output logic            cnt_load,
   output logic [DW-1:0]   cnt_d,
   output logic            busy,
   output logic            done,
   output logic            err
);

   localparam logic [DW:0] MOD_LIM = MOD_U[DW:0];

   logic [ST_W-1:0] state_q, state_d;
   logic [DW-1:0]   target_q, target_d;
   logic [DW-1:0]   data_q, data_d;
   logic            en_q, en_d;
   logic            clr_q, clr_d;
   logic            up_q, up_d;
   logic            load_q, load_d;
   logic            busy_q, busy_d;
   logic            done_q, done_d;
   logic            err_q, err_d;
   logic            ready_q, ready_d;
   logic            accept_s;
   logic            data_ok_s;

   assign accept_s  = cmd_valid & ready_q;
   assign data_ok_s = ({1'b0, cmd_data} < MOD_LIM);

   // Next-state and strobe decode; an accepted op always takes priority over a tick.
   always_comb begin
      state_d  = state_q;
      target_d = target_q;
      data_d   = data_q;
      up_d     = up_q;
      en_d     = 1'b0;
      clr_d    = 1'b0;
      load_d   = 1'b0;
      done_d   = 1'b0;
      err_d    = 1'b0;
      if (accept_s && (cmd_op != OP_NOP)) begin
         case (cmd_op)
            OP_CLEAR: begin
               state_d = ST_CLR;
               clr_d   = 1'b1;
            end
            OP_LOAD: begin
               if (data_ok_s) begin
                  state_d = ST_LD;
                  load_d  = 1'b1;
                  data_d  = cmd_data;
               end else begin
                  err_d = 1'b1;
               end
            end
            OP_RUN_UP: begin
               state_d = ST_RUN;
               up_d    = 1'b1;
            end
            OP_RUN_DN: begin
               state_d = ST_RUN;
               up_d    = 1'b0;
            end
            OP_STOP: begin
               state_d = ST_IDLE;
            end
            OP_RUN_TO: begin
               if (data_ok_s) begin
                  state_d  = ST_RUNTO;
                  target_d = cmd_data;
               end else begin
                  err_d = 1'b1;
               end
            end
            OP_STEP: begin
               state_d = ST_STEP;
            end
            default: begin
               state_d = state_q;
            end
         endcase
      end else begin
         case (state_q)
            ST_CLR, ST_LD: begin
               state_d = ST_IDLE;
            end
            ST_RUN: begin
               en_d = tick_in;
            end
            ST_RUNTO: begin
               if (cnt_q == target_q) begin
                  done_d  = 1'b1;
                  state_d = ST_IDLE;
               end else begin
                  en_d = tick_in;
               end
            end
            ST_STEP: begin
               if (tick_in) begin
                  en_d    = 1'b1;
                  done_d  = 1'b1;
                  state_d = ST_IDLE;
               end else begin
                  state_d = ST_STEP;
               end
            end
            default: begin
               state_d = ST_IDLE;
            end
         endcase
      end
      busy_d  = (state_d != ST_IDLE);
      ready_d = ready_in_state(state_d);
   end

   // State and output registers; reset cancels any pending strobe and the target.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         target_q <= {DW{1'b0}};
         data_q   <= {DW{1'b0}};
         up_q     <= 1'b1;
         en_q     <= 1'b0;
         clr_q    <= 1'b0;
         load_q   <= 1'b0;
         done_q   <= 1'b0;
         err_q    <= 1'b0;
         busy_q   <= 1'b0;
         ready_q  <= 1'b1;
      end else begin
         state_q  <= state_d;
         target_q <= target_d;
         data_q   <= data_d;
         up_q     <= up_d;
         en_q     <= en_d;
         clr_q    <= clr_d;
         load_q   <= load_d;
         done_q   <= done_d;
         err_q    <= err_d;
         busy_q   <= busy_d;
         ready_q  <= ready_d;
      end
   end

   assign cmd_ready = ready_q;
   assign cnt_en    = en_q;
   assign cnt_clr   = clr_q;
   assign cnt_up    = up_q;
   assign cnt_load  = load_q;
   assign cnt_d     = data_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign err       = err_q;

endmodule

// File: tb/tb_mod_u_cnt_ctrl.sv
// Scoreboard bench for mod_u_cnt_ctrl with a behavioural mod-10 counter in the loop.
module tb_mod_u_cnt_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic       tick_in;
   logic       cmd_valid;
   logic       cmd_ready;
   logic [2:0] cmd_op;
   logic [3:0] cmd_data;
   logic [3:0] cnt;
   logic       cnt_en, cnt_clr, cnt_up, cnt_load, busy, done, err;
   logic [3:0] cnt_d;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   typedef struct {
      int         c;
      logic       en, clr, load, done, err, up;
      logic [3:0] d;
   } exp_t;
   exp_t exp_q[$];

   mod_u_cnt_ctrl #(.DW(4), .MOD_U(10)) dut (
      .clk(clk), .rst(rst), .tick_in(tick_in),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_data(cmd_data),
      .cnt_q(cnt), .cnt_en(cnt_en), .cnt_clr(cnt_clr), .cnt_up(cnt_up),
      .cnt_load(cnt_load), .cnt_d(cnt_d), .busy(busy), .done(done), .err(err)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Counter datapath stand-in driven by the controller strobes
   always @(posedge clk) begin
      if (rst) cnt <= 4'd0;
      else if (cnt_clr) cnt <= 4'd0;
      else if (cnt_load) cnt <= cnt_d;
      else if (cnt_en) cnt <= cnt_up ? ((cnt == 4'd9) ? 4'd0 : cnt + 4'd1)
                                     : ((cnt == 4'd0) ? 4'd9 : cnt - 4'd1);
   end

   // Monitor: every strobe cycle must match the next queued expectation
   always @(negedge clk) begin
      exp_t e;
      if (cnt_en === 1'b1 || cnt_clr === 1'b1 || cnt_load === 1'b1 || done === 1'b1 || err === 1'b1) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_strobe cyc=%0d got en=%b clr=%b ld=%b done=%b err=%b, required no strobe",
                     cyc, cnt_en, cnt_clr, cnt_load, done, err);
         end else begin
            e = exp_q.pop_front();
            if (cyc != e.c || cnt_en !== e.en || cnt_clr !== e.clr || cnt_load !== e.load ||
                done !== e.done || err !== e.err || (e.load && cnt_d !== e.d) || (e.en && cnt_up !== e.up)) begin
               errors++;
               $display("FAIL strobe got cyc=%0d en=%b clr=%b ld=%b d=%0d done=%b err=%b up=%b, required cyc=%0d en=%b clr=%b ld=%b d=%0d done=%b err=%b up=%b",
                        cyc, cnt_en, cnt_clr, cnt_load, cnt_d, done, err, cnt_up,
                        e.c, e.en, e.clr, e.load, e.d, e.done, e.err, e.up);
            end
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s got %0d required %0d", name, act, req);
      end
   endtask

   task automatic push(input int c, input logic en, input logic clr, input logic load,
                       input logic [3:0] d, input logic dn, input logic er, input logic up);
      exp_t e;
      e.c = c; e.en = en; e.clr = clr; e.load = load; e.d = d; e.done = dn; e.err = er; e.up = up;
      exp_q.push_back(e);
   endtask

   task automatic wait_ready();
      int w = 0;
      while (cmd_ready !== 1'b1 && w < 20) begin
         step();
         w++;
      end
      if (w >= 20) chk("ready_timeout", 0, 1);
   endtask

   task automatic send(input logic [2:0] op, input logic [3:0] data);
      cmd_valid = 1'b1;
      cmd_op    = op;
      cmd_data  = data;
      step();
      cmd_valid = 1'b0;
      cmd_op    = 3'd0;
      cmd_data  = 4'd0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired at cyc=%0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [3:0] exp_up [4];
      int last;
      exp_up = '{4'd9, 4'd0, 4'd1, 4'd2};
      rst = 1'b1; tick_in = 1'b0; cmd_valid = 1'b0; cmd_op = 3'd0; cmd_data = 4'd0;
      step(); step();
      chk("reset_up", int'(cnt_up), 1);
      chk("reset_busy", int'(busy), 0);
      chk("reset_ready", int'(cmd_ready), 1);
      chk("reset_strobes", int'({cnt_en, cnt_clr, cnt_load, done, err}), 0);
      chk("reset_cnt_d", int'(cnt_d), 0);
      rst = 1'b0;
      step();

      // Load legal and illegal values
      wait_ready(); push(cyc + 1, 1'b0, 1'b0, 1'b1, 4'd7, 1'b0, 1'b0, 1'b1); send(3'd2, 4'd7);
      chk("ld_ready_low", int'(cmd_ready), 0);
      step();
      chk("load_value", int'(cnt), 7);
      wait_ready(); push(cyc + 1, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b1); send(3'd2, 4'd12);
      step();
      chk("bad_load_keeps_cnt", int'(cnt), 7);
      wait_ready(); push(cyc + 1, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b1); send(3'd6, 4'd10);
      step();
      chk("bad_runto_idle", int'(busy), 0);

      // Free run up from 8 across the wrap, then stop with a coincident tick
      wait_ready(); push(cyc + 1, 1'b0, 1'b0, 1'b1, 4'd8, 1'b0, 1'b0, 1'b1); send(3'd2, 4'd8);
      step();
      wait_ready(); send(3'd3, 4'd0);
      chk("run_busy", int'(busy), 1);
      chk("run_ready", int'(cmd_ready), 1);
      for (int i = 0; i < 4; i++) begin
         tick_in = 1'b1; push(cyc + 1, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1); step();
         tick_in = 1'b0; step();
         chk("run_up_cnt", int'(cnt), int'(exp_up[i]));
      end
      tick_in = 1'b1; send(3'd5, 4'd0); tick_in = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick_in = 1'b1; step(); tick_in = 1'b0; step();
      end
      chk("stop_idle", int'(busy), 0);
      chk("stop_cnt", int'(cnt), 2);

      // Run down to 9 from 2
      wait_ready(); send(3'd4, 4'd0); send(3'd5, 4'd0);
      chk("dir_down", int'(cnt_up), 0);
      send(3'd6, 4'd9);
      chk("runto_busy", int'(busy), 1);
      last = 0;
      for (int i = 0; i < 3; i++) begin
         tick_in = 1'b1; last = cyc; push(cyc + 1, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0); step();
         tick_in = 1'b0; step(); step();
      end
      push(last + 3, 1'b0, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
      chk("runto_cnt", int'(cnt), 9);
      chk("runto_idle", int'(busy), 0);
      for (int i = 0; i < 2; i++) begin
         tick_in = 1'b1; step(); tick_in = 1'b0; step();
      end

      // Single step with a late tick, then CLEAR coincident with a tick in RUN
      wait_ready(); send(3'd7, 4'd0);
      chk("step_busy", int'(busy), 1);
      chk("step_ready", int'(cmd_ready), 0);
      step(); step(); step(); step();
      tick_in = 1'b1; push(cyc + 1, 1'b1, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0); step();
      tick_in = 1'b0; step();
      chk("step_cnt", int'(cnt), 8);
      chk("step_idle", int'(busy), 0);
      wait_ready(); send(3'd3, 4'd0);
      tick_in = 1'b1; push(cyc + 1, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1); send(3'd1, 4'd0);
      tick_in = 1'b0;
      chk("clr_ready_low", int'(cmd_ready), 0);
      step();
      chk("clr_cnt", int'(cnt), 0);

      // Reset in the middle of a run-to
      wait_ready(); push(cyc + 1, 1'b0, 1'b0, 1'b1, 4'd3, 1'b0, 1'b0, 1'b1); send(3'd2, 4'd3);
      step();
      wait_ready(); send(3'd6, 4'd7);
      tick_in = 1'b1; push(cyc + 1, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1); step();
      tick_in = 1'b0; step();
      chk("pre_rst_cnt", int'(cnt), 4);
      rst = 1'b1; tick_in = 1'b1; step();
      rst = 1'b0; tick_in = 1'b0;
      chk("rst_busy", int'(busy), 0);
      chk("rst_up", int'(cnt_up), 1);
      chk("rst_ready", int'(cmd_ready), 1);
      chk("rst_strobes", int'({cnt_en, cnt_clr, cnt_load, done, err}), 0);
      for (int i = 0; i < 6; i++) step();

      chk("queue_empty", exp_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
